// File: rtl/mem_responder.sv
// Word-addressed memory responder: READY/BUSY latency FSM in front of a storage array, with a tri-state data bus.
// Optional feature macro MEM_RESP_RANGE_CHECK_EN: accesses at or beyond MEM_DEPTH read zero, drop writes and raise MEM_ERR.
module mem_responder #(
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic                  MEM_READ,
    input  logic                  MEM_WRITE,
    inout  wire  [DATA_WIDTH-1:0] MEM_DATA,
    output logic                  MEM_READY,
    output logic                  MEM_BUSY,
    output logic                  MEM_ERR
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

`ifdef MEM_RESP_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_HOLD = 3'd2,
        WR_WAIT = 3'd3,
        WR_HOLD = 3'd4
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [IDX_W-1:0]        addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    oor_reg, oor_next;
    logic                    ready_next, busy_next, err_next;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic rd_req, wr_req, addr_oor, rd_fire, wr_fire, drive_bus;

    // 11 and 00 are both no-ops
    assign rd_req   = MEM_READ & ~MEM_WRITE;
    assign wr_req   = MEM_WRITE & ~MEM_READ;
    assign addr_oor = RANGE_CHECK && ({1'b0, MEM_ADDR} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));

    assign rd_fire = (state_reg == RD_WAIT) && (cnt_reg == 4'd0);
    assign wr_fire = (state_reg == WR_WAIT) && (cnt_reg == 4'd0) && !oor_reg;

    // State register, captured request and registered flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            oor_reg   <= 1'b0;
            MEM_READY <= 1'b0;
            MEM_BUSY  <= 1'b0;
            MEM_ERR   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            oor_reg   <= oor_next;
            MEM_READY <= ready_next;
            MEM_BUSY  <= busy_next;
            MEM_ERR   <= err_next;
            if (rd_fire) begin
                rdata_reg <= oor_reg ? '0 : mem[addr_reg];
            end
        end
    end

    // Array write port kept free of reset so it maps onto block RAM
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        oor_next   = oor_reg;
        case (state_reg)
            IDLE: begin
                if (rd_req) begin
                    state_next = RD_WAIT;
                    cnt_next   = RD_LOAD;
                    addr_next  = MEM_ADDR[IDX_W-1:0];
                    oor_next   = addr_oor;
                end else if (wr_req) begin
                    state_next = WR_WAIT;
                    cnt_next   = WR_LOAD;
                    addr_next  = MEM_ADDR[IDX_W-1:0];
                    wdata_next = MEM_DATA;
                    oor_next   = addr_oor;
                end
            end
            RD_WAIT: begin
                if (cnt_reg == 4'd0) state_next = RD_HOLD;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            RD_HOLD: begin
                if (!MEM_READ) state_next = IDLE;
            end
            WR_WAIT: begin
                if (cnt_reg == 4'd0) state_next = WR_HOLD;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            WR_HOLD: begin
                if (!MEM_WRITE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: flags follow the state being entered so they register alongside it
    always_comb begin
        ready_next = (state_next == RD_HOLD) || (state_next == WR_HOLD);
        busy_next  = (state_next == RD_WAIT) || (state_next == WR_WAIT);
        err_next   = ready_next && oor_next;
    end

    // Bus released the moment the master stops a pure read, so a turn to write never contends
    assign drive_bus = (state_reg == RD_HOLD) && MEM_READ && !MEM_WRITE;
    assign MEM_DATA  = drive_bus ? rdata_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed accesses push expected responses, a negedge monitor checks them.
// The bench idles the data bus at its own value, so any stray responder drive shows up as a changed bus value.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] tb_wdata;
    wire  [31:0] mem_data;
    logic        mem_ready;
    logic        mem_busy;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    resp_t mon_e;
    logic  ready_d = 1'b0;

    // Master drives the bus whenever it is not issuing a pure read
    assign mem_data = (mem_read && !mem_write) ? {32{1'bz}} : tb_wdata;

    mem_responder #(
        .ADDR_WIDTH   (26),
        .DATA_WIDTH   (32),
        .MEM_DEPTH    (1024),
        .READ_LATENCY (2),
        .WRITE_LATENCY(3)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .MEM_ADDR (mem_addr),
        .MEM_READ (mem_read),
        .MEM_WRITE(mem_write),
        .MEM_DATA (mem_data),
        .MEM_READY(mem_ready),
        .MEM_BUSY (mem_busy),
        .MEM_ERR  (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic is_rd, input logic [31:0] data, input logic err);
        resp_t e;
        e.is_rd = is_rd;
        e.data  = data;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // Count busy cycles from request issue until READY, bounded
    task automatic wait_ready(input string name, input int exp_busy);
        int busy_n;
        bit got;
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (mem_ready) got = 1'b1;
            else begin
                if (mem_busy) busy_n++;
                tick();
            end
        end
        check({name, "_ready_seen"}, 32'(got), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    endtask

    task automatic wr_access(input logic [25:0] addr, input logic [31:0] data, input logic err);
        mem_addr  = addr;
        tb_wdata  = data;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        push(1'b0, 32'h0, err);
        wait_ready("wr", 3);
        tick();
        check("wr_hold_ready", 32'(mem_ready), 32'd1);
        mem_write = 1'b0;
        tb_wdata  = 32'h0;
        tick();
        check("wr_exit_ready", 32'(mem_ready), 32'd0);
    endtask

    task automatic rd_access(input logic [25:0] addr, input logic [31:0] exp, input logic err);
        mem_addr  = addr;
        tb_wdata  = 32'h0;
        mem_write = 1'b0;
        mem_read  = 1'b1;
        push(1'b1, exp, err);
        wait_ready("rd", 2);
        tick();
        check("rd_hold_data", mem_data, exp);
        mem_read = 1'b0;
        #1;
        check("rd_release_z", mem_data, 32'h0);
        tick();
        check("rd_exit_ready", 32'(mem_ready), 32'd0);
    endtask

    // Monitor: one scoreboard entry per new READY assertion
    always @(negedge clk) begin
        if (!rst) begin
            ready_d = 1'b0;
        end else begin
            if (mem_ready && !ready_d) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready actual=1 required=0 data=%h", mem_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("mon_err", 32'(mem_err), 32'(mon_e.err));
                    if (mon_e.is_rd) check("mon_rdata", mem_data, mon_e.data);
                end
            end
            ready_d = mem_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b0;
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tb_wdata  = 32'h0;
        tick();
        tick();
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy",  32'(mem_busy),  32'd0);
        check("rst_err",   32'(mem_err),   32'd0);
        check("rst_bus_z", mem_data,       32'h0);
        rst = 1'b1;
        tick();

        // Reset during WR_WAIT discards the pending write
        wr_access(26'd5, 32'h0BADF00D, 1'b0);
        mem_addr  = 26'd5;
        tb_wdata  = 32'hDEADBEEF;
        mem_write = 1'b1;
        tick();
        check("abort_accept_busy", 32'(mem_busy), 32'd1);
        tick();
        rst       = 1'b0;
        mem_write = 1'b0;
        tb_wdata  = 32'h0;
        #1;
        check("abort_ready", 32'(mem_busy | mem_ready), 32'd0);
        check("abort_err",   32'(mem_err),  32'd0);
        check("abort_bus_z", mem_data,      32'h0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rd_access(26'd5, 32'h0BADF00D, 1'b0);

        // Write then read
        wr_access(26'd3, 32'h12345678, 1'b0);
        rd_access(26'd3, 32'h12345678, 1'b0);

        // Held write with changing data commits only the first word
        mem_addr  = 26'd9;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        tb_wdata  = 32'h30000000;
        push(1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            tb_wdata = 32'h30000000 + 32'(i);
        end
        check("held_wr_ready", 32'(mem_ready), 32'd1);
        check("held_wr_busy",  32'(mem_busy),  32'd0);
        mem_write = 1'b0;
        tb_wdata  = 32'h0;
        tick();
        check("held_wr_exit", 32'(mem_ready), 32'd0);
        rd_access(26'd9, 32'h30000000, 1'b0);

        // Both request lines high is a no-op
        mem_read  = 1'b1;
        mem_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("noop_ready", 32'(mem_ready), 32'd0);
            check("noop_busy",  32'(mem_busy),  32'd0);
            check("noop_bus_z", mem_data,       32'h0);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();

        // Read-to-write turnaround on the same edge
        mem_addr = 26'd3;
        mem_read = 1'b1;
        push(1'b1, 32'h12345678, 1'b0);
        wait_ready("ta_rd", 2);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b1;
        mem_addr  = 26'd12;
        tb_wdata  = 32'hCAFEF00D;
        push(1'b0, 32'h0, 1'b0);
        #1;
        check("ta_bus_z", mem_data, 32'hCAFEF00D);
        tick();
        check("ta_idle_busy",  32'(mem_busy),  32'd0);
        check("ta_idle_ready", 32'(mem_ready), 32'd0);
        tick();
        check("ta_accept_busy", 32'(mem_busy), 32'd1);
        wait_ready("ta_wr", 3);
        mem_write = 1'b0;
        tb_wdata  = 32'h0;
        tick();
        rd_access(26'd12, 32'hCAFEF00D, 1'b0);

        // Address beyond MEM_DEPTH
        wr_access(26'd7, 32'h77777777, 1'b0);
`ifdef MEM_RESP_RANGE_CHECK_EN
        wr_access(26'd1031, 32'hA5A5A5A5, 1'b1);
        rd_access(26'd7,    32'h77777777, 1'b0);
        rd_access(26'd1031, 32'h00000000, 1'b1);
`else
        wr_access(26'd1031, 32'hA5A5A5A5, 1'b0);
        rd_access(26'd7,    32'hA5A5A5A5, 1'b0);
        rd_access(26'd1031, 32'hA5A5A5A5, 1'b0);
`endif

        tick();
        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
